// File: rtl/emsensor_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : emsensor_pkg                                                   |
// | Purpose : Shared definitions for the EM/timing sensor sequencer.         |
// |           Holds the FSM state encoding (3-bit, IDLE..ALERT) and the      |
// |           default reset-pulse length and sensitivity-code width.         |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package emsensor_pkg;

  // Encodings are visible to software through state_o, so they are fixed.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RESET  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CALIB  = 3'd3,
    ST_ARMED  = 3'd4,
    ST_ALERT  = 3'd5
  } state_e;

  localparam int RST_CYC_DEF = 16;
  localparam int SENS_W_DEF  = 5;

endpackage : emsensor_pkg
`default_nettype wire

// File: rtl/emsensor_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : emsensor_debounce                                              |
// | Purpose : Counts consecutive alarm cycles and flags the cycle on which   |
// |           the run length reaches the threshold.                          |
// | Ports   : clk, rst_n      clock, async active-low reset                  |
// |           clr             forces the count to 0                          |
// |           alarm           OR-reduced alarm level                         |
// |           threshold[3:0]  required run length (0 behaves as 1)           |
// |           hit             combinational: this alarm cycle completes run  |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module emsensor_debounce (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       alarm,
  input  logic [3:0] threshold,
  output logic       hit
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  logic [3:0] thr_eff;

  assign thr_eff = (threshold == 4'd0) ? 4'd1 : threshold;

  // hit looks at the count this alarm cycle will produce, so the alert
  // registers on the same edge the run length reaches the threshold.
  assign hit = alarm && !clr &&
               (({1'b0, cnt_q} + 5'd1) >= {1'b0, thr_eff});

  always_comb begin
    cnt_d = cnt_q;
    if (clr || !alarm) begin
      cnt_d = 4'd0;
    end else if (cnt_q != 4'hF) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : emsensor_debounce
`default_nettype wire

// File: rtl/emsensor_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : emsensor_sequencer                                             |
// | Purpose : Bring-up / run-time sequencer for the EM and timing sensors:   |
// |           reset banks, settle and clear alarms, sweep-calibrate the      |
// |           timing-sensor sensitivity, then debounce alarms into a latched |
// |           alert held until software acks.                                |
// | Ports   : vclk, vrst            clock, async active-low reset            |
// |           arm, ack              run level / alert acknowledge pulse      |
// |           cfg_*                 settle, dwell, margin, debounce settings |
// |           bank_alarm, talarm_any  sensor alarm inputs                    |
// |           sensor_rst_n, alarm_clr, sensitivity  sensor controls          |
// |           cal_done, cal_fail, alert, alert_src, state_o  status          |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module emsensor_sequencer
  import emsensor_pkg::*;
#(
  parameter int NBANK   = 5,
  parameter int SENS_W  = SENS_W_DEF,
  parameter int RST_CYC = RST_CYC_DEF,
  parameter int CNT_W   = 16
) (
  input  logic              vclk,
  input  logic              vrst,
  input  logic              arm,
  input  logic              ack,
  input  logic [CNT_W-1:0]  cfg_settle,
  input  logic [CNT_W-1:0]  cfg_dwell,
  input  logic [SENS_W-1:0] cfg_margin,
  input  logic [3:0]        cfg_debounce,
  input  logic [NBANK-1:0]  bank_alarm,
  input  logic              talarm_any,
  output logic              sensor_rst_n,
  output logic              alarm_clr,
  output logic [SENS_W-1:0] sensitivity,
  output logic              cal_done,
  output logic              cal_fail,
  output logic              alert,
  output logic [NBANK:0]    alert_src,
  output logic [2:0]        state_o
);

  localparam logic [CNT_W-1:0]  RST_LAST = CNT_W'(RST_CYC - 1);
  localparam logic [SENS_W-1:0] SENS_MAX = '1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SENS_W-1:0] sens_q, sens_d;
  logic              cal_done_q, cal_done_d;
  logic              cal_fail_q, cal_fail_d;
  logic              alert_q, alert_d;
  logic [NBANK:0]    alert_src_q, alert_src_d;
  logic              sensor_rst_n_q, sensor_rst_n_d;
  logic              alarm_clr_q, alarm_clr_d;

  logic [NBANK:0]    alarm_vec;
  logic [CNT_W-1:0]  settle_last;
  logic [CNT_W-1:0]  dwell_last;
  logic              deb_clr;
  logic              deb_hit;

  assign alarm_vec   = {talarm_any, bank_alarm};
  // Last count index of a phase; a zero setting behaves as a length of 1.
  assign settle_last = (cfg_settle == '0) ? '0 : cfg_settle - 1'b1;
  assign dwell_last  = (cfg_dwell  == '0) ? '0 : cfg_dwell  - 1'b1;
  // Dropping arm clears the debounce count on the same edge as the FSM.
  assign deb_clr     = (state_q != ST_ARMED) || !arm;

  emsensor_debounce u_debounce (
    .clk       (vclk),
    .rst_n     (vrst),
    .clr       (deb_clr),
    .alarm     (|alarm_vec),
    .threshold (cfg_debounce),
    .hit       (deb_hit)
  );

  // Phase counters only increment while below their last index, which is at
  // most all-ones minus one, so they can never wrap.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sens_d      = sens_q;
    cal_done_d  = cal_done_q;
    cal_fail_d  = cal_fail_q;
    alert_d     = alert_q;
    alert_src_d = alert_src_q;

    unique case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d = ST_RESET;
          cnt_d   = '0;
        end
      end
      ST_RESET: begin
        if (cnt_q >= RST_LAST) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SETTLE: begin
        if (cnt_q >= settle_last) begin
          cnt_d = '0;
          if (cal_done_q) begin
            state_d = ST_ARMED;
          end else begin
            state_d = ST_CALIB;
            sens_d  = '0;   // sweep always starts from the lowest code
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_CALIB: begin
        if (talarm_any) begin
          sens_d     = (sens_q > cfg_margin) ? sens_q - cfg_margin : '0;
          cal_done_d = 1'b1;
          state_d    = ST_SETTLE;
          cnt_d      = '0;
        end else if (cnt_q >= dwell_last) begin
          cnt_d = '0;
          if (sens_q == SENS_MAX) begin
            cal_fail_d = 1'b1;
            cal_done_d = 1'b1;
            sens_d     = '0;
            state_d    = ST_SETTLE;
          end else begin
            sens_d = sens_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ARMED: begin
        if (deb_hit) begin
          alert_d     = 1'b1;
          alert_src_d = alarm_vec;
          state_d     = ST_ALERT;
        end
      end
      ST_ALERT: begin
        if (ack) begin
          alert_d     = 1'b0;
          alert_src_d = '0;
          state_d     = ST_SETTLE;
          cnt_d       = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Disarm overrides everything, including a coincident ack; calibration
    // results survive so the next arm goes straight to monitoring.
    if (!arm) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      alert_d     = 1'b0;
      alert_src_d = '0;
    end

    // Sensor controls follow the state being entered so they line up with
    // state_o on the same cycle.
    sensor_rst_n_d = !((state_d == ST_IDLE) || (state_d == ST_RESET));
    alarm_clr_d    = (state_d == ST_IDLE) || (state_d == ST_RESET) ||
                     (state_d == ST_SETTLE);
  end

  always_ff @(posedge vclk or negedge vrst) begin
    if (!vrst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      sens_q         <= '0;
      cal_done_q     <= 1'b0;
      cal_fail_q     <= 1'b0;
      alert_q        <= 1'b0;
      alert_src_q    <= '0;
      sensor_rst_n_q <= 1'b0;
      alarm_clr_q    <= 1'b1;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      sens_q         <= sens_d;
      cal_done_q     <= cal_done_d;
      cal_fail_q     <= cal_fail_d;
      alert_q        <= alert_d;
      alert_src_q    <= alert_src_d;
      sensor_rst_n_q <= sensor_rst_n_d;
      alarm_clr_q    <= alarm_clr_d;
    end
  end

  assign sensor_rst_n = sensor_rst_n_q;
  assign alarm_clr    = alarm_clr_q;
  assign sensitivity  = sens_q;
  assign cal_done     = cal_done_q;
  assign cal_fail     = cal_fail_q;
  assign alert        = alert_q;
  assign alert_src    = alert_src_q;
  assign state_o      = state_q;

endmodule : emsensor_sequencer
`default_nettype wire

// File: tb/tb_emsensor_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_emsensor_sequencer                                          |
// | Purpose : Directed self-checking bench for emsensor_sequencer: bring-up  |
// |           timing, calibration sweep, debounce, ack/disarm, async reset.  |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_emsensor_sequencer;

  logic        vclk = 1'b0;
  logic        vrst;
  logic        arm, ack;
  logic [15:0] cfg_settle, cfg_dwell;
  logic [4:0]  cfg_margin;
  logic [3:0]  cfg_debounce;
  logic [4:0]  bank_alarm;
  logic        talarm_any;
  logic        sensor_rst_n, alarm_clr;
  logic [4:0]  sensitivity;
  logic        cal_done, cal_fail, alert;
  logic [5:0]  alert_src;
  logic [2:0]  state_o;

  int checks = 0;
  int errors = 0;

  emsensor_sequencer dut (
    .vclk         (vclk),
    .vrst         (vrst),
    .arm          (arm),
    .ack          (ack),
    .cfg_settle   (cfg_settle),
    .cfg_dwell    (cfg_dwell),
    .cfg_margin   (cfg_margin),
    .cfg_debounce (cfg_debounce),
    .bank_alarm   (bank_alarm),
    .talarm_any   (talarm_any),
    .sensor_rst_n (sensor_rst_n),
    .alarm_clr    (alarm_clr),
    .sensitivity  (sensitivity),
    .cal_done     (cal_done),
    .cal_fail     (cal_fail),
    .alert        (alert),
    .alert_src    (alert_src),
    .state_o      (state_o)
  );

  always #5 vclk = ~vclk;

  task automatic step();
    @(negedge vclk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts negedges spent in state st; notes any cycle with the sensor
  // out of reset or with the alarm clear dropped.
  task automatic run_in(input logic [2:0] st, output int n,
                        output logic rstn_hi, output logic clr_lo);
    n = 0; rstn_hi = 1'b0; clr_lo = 1'b0;
    while (state_o == st && n < 200) begin
      if (sensor_rst_n !== 1'b0) rstn_hi = 1'b1;
      if (alarm_clr !== 1'b1) clr_lo = 1'b1;
      n++;
      step();
    end
  endtask

  task automatic wait_sens(input logic [4:0] code, output int n);
    n = 0;
    while (sensitivity !== code && n < 500) begin
      step();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic hi, lo;

    vrst = 1'b0; arm = 1'b0; ack = 1'b0;
    cfg_settle = 16'd10; cfg_dwell = 16'd4; cfg_margin = 5'd2; cfg_debounce = 4'd3;
    bank_alarm = 5'd0; talarm_any = 1'b0;

    // Reset values
    step(); step();
    chk("rst_state", state_o, 3'd0);
    chk("rst_rstn", sensor_rst_n, 1'b0);
    chk("rst_clr", alarm_clr, 1'b1);
    chk("rst_sens", sensitivity, 5'd0);
    chk("rst_flags", {cal_done, cal_fail, alert}, 3'b000);
    chk("rst_src", alert_src, 6'd0);
    vrst = 1'b1;
    step();
    chk("idle_hold", {state_o, sensor_rst_n, alarm_clr}, {3'd0, 1'b0, 1'b1});

    // 1: bring-up timing
    arm = 1'b1;
    step();
    chk("enter_reset", state_o, 3'd1);
    run_in(3'd1, n, hi, lo);
    chk("reset_len", n, 16);
    chk("reset_rstn_low", hi, 1'b0);
    chk("settle_rstn", {state_o, sensor_rst_n}, {3'd2, 1'b1});
    run_in(3'd2, n, hi, lo);
    chk("settle_len", n, 10);
    chk("settle_clr_high", lo, 1'b0);
    chk("calib_entry", {state_o, alarm_clr, sensitivity}, {3'd3, 1'b0, 5'd0});

    // 2: trip at code 9, margin 2
    wait_sens(5'd9, n);
    chk("dwell_to_code9", n, 36);
    talarm_any = 1'b1;
    step();
    talarm_any = 1'b0;
    chk("cal_sens", sensitivity, 5'd7);
    chk("cal_flags", {cal_done, cal_fail, state_o}, {1'b1, 1'b0, 3'd2});
    run_in(3'd2, n, hi, lo);
    chk("resettle_len", n, 10);
    chk("armed", {state_o, sensitivity}, {3'd4, 5'd7});

    // ack outside ALERT is ignored
    ack = 1'b1; step(); ack = 1'b0;
    chk("ack_ignored", state_o, 3'd4);

    // 4: debounce, 2 cycles then 3 cycles
    bank_alarm = 5'b00100;
    step(); step();
    bank_alarm = 5'd0;
    step(); step();
    chk("deb_short", {alert, state_o}, {1'b0, 3'd4});
    bank_alarm = 5'b00100;
    step(); step();
    chk("deb_minus1", alert, 1'b0);
    step();
    chk("deb_hit", {alert, alert_src, state_o}, {1'b1, 6'b000100, 3'd5});
    bank_alarm = 5'd0;
    step(); step();
    chk("alert_hold", {alert, alert_src, state_o}, {1'b1, 6'b000100, 3'd5});

    // 5: ack -> SETTLE -> ARMED without CALIB
    ack = 1'b1; step(); ack = 1'b0;
    chk("ack_clear", {alert, alert_src, state_o}, {1'b0, 6'd0, 3'd2});
    run_in(3'd2, n, hi, lo);
    chk("ack_settle_len", n, 10);
    chk("rearmed_nocal", {state_o, sensitivity}, {3'd4, 5'd7});
    talarm_any = 1'b1;
    step(); step(); step();
    talarm_any = 1'b0;
    chk("talarm_alert", {alert, alert_src, state_o}, {1'b1, 6'b100000, 3'd5});
    ack = 1'b1; arm = 1'b0;
    step();
    ack = 1'b0;
    chk("disarm_wins", {state_o, alert, alert_src}, {3'd0, 1'b0, 6'd0});
    chk("disarm_keep", {cal_done, cal_fail, sensitivity}, {1'b1, 1'b0, 5'd7});
    chk("disarm_outs", {sensor_rst_n, alarm_clr}, 2'b01);
    arm = 1'b1;
    step();
    run_in(3'd1, n, hi, lo);
    chk("rearm_reset_len", n, 16);
    run_in(3'd2, n, hi, lo);
    chk("rearm_skip_cal", state_o, 3'd4);

    // 3a: margin saturation
    vrst = 1'b0; step(); vrst = 1'b1; cfg_margin = 5'd5;
    step();
    run_in(3'd1, n, hi, lo);
    run_in(3'd2, n, hi, lo);
    wait_sens(5'd3, n);
    chk("dwell_to_code3", n, 12);
    talarm_any = 1'b1; step(); talarm_any = 1'b0;
    chk("sat_sens", {sensitivity, cal_done, cal_fail, state_o}, {5'd0, 1'b1, 1'b0, 3'd2});

    // 3b: full sweep without trip
    vrst = 1'b0; step(); vrst = 1'b1; cfg_dwell = 16'd2;
    step();
    run_in(3'd1, n, hi, lo);
    run_in(3'd2, n, hi, lo);
    chk("sweep_start", state_o, 3'd3);
    run_in(3'd3, n, hi, lo);
    chk("sweep_len", n, 64);
    chk("cal_fail", {cal_fail, cal_done, sensitivity, state_o}, {1'b1, 1'b1, 5'd0, 3'd2});

    // 6: async reset in CALIB at code 12
    vrst = 1'b0; step(); vrst = 1'b1; cfg_dwell = 16'd4;
    step();
    run_in(3'd1, n, hi, lo);
    run_in(3'd2, n, hi, lo);
    wait_sens(5'd12, n);
    chk("dwell_to_code12", n, 48);
    #2 vrst = 1'b0;
    #1;
    chk("async_state", state_o, 3'd0);
    chk("async_outs", {sensor_rst_n, alarm_clr, sensitivity}, {1'b0, 1'b1, 5'd0});
    chk("async_flags", {cal_done, cal_fail, alert, alert_src}, 9'd0);
    step();
    vrst = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_emsensor_sequencer
`default_nettype wire
